// File: rtl/gcd_arbiter.sv
// Round-robin arbiter that shares one gcd unit among NREQ requesters and answers zero operands locally.
// Optional watchdog on the WAIT state is enabled by defining GCD_ARB_TIMEOUT_EN.
module gcd_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int TO_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_ret,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  gcd_start,
  output logic [WIDTH-1:0]      gcd_a,
  output logic [WIDTH-1:0]      gcd_b,
  input  logic                  gcd_done,
  input  logic [WIDTH-1:0]      gcd_ret
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, RESP} state_t;

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    winner;
  logic [IW-1:0]    pick;
  logic [NREQ-1:0]  pick_oh;
  logic             any_req;
  logic [WIDTH-1:0] pick_a;
  logic [WIDTH-1:0] pick_b;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             timeout;

  // Rotating priority: scan from ptr upward, wrapping at NREQ.
  always_comb begin : arb
    int idx;
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    pick    = ptr;
    any_req = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        pick    = IW'(idx);
      end
    end
    pick_oh = NREQ'(1) << pick;
    pick_a  = req_a[int'(pick)*WIDTH +: WIDTH];
    pick_b  = req_b[int'(pick)*WIDTH +: WIDTH];
  end

  assign gcd_a = op_a;
  assign gcd_b = op_b;

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES + 1);

  logic [TW-1:0] wd_cnt;
  logic          err_q;

  // Counter sits at zero outside WAIT, so it is clear on every entry to WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      wd_cnt <= (state == WAIT) ? wd_cnt + 1'b1 : '0;
      if (state == WAIT && (gcd_done || timeout)) err_q <= !gcd_done;
      else if (state == IDLE && any_req)          err_q <= 1'b0;
    end
  end

  assign timeout = (state == WAIT) && (wd_cnt == TW'(TO_CYCLES - 1));
  assign rsp_err = err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // NOTE: all state and registered outputs use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      winner    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_ret   <= '0;
      busy      <= 1'b0;
      gcd_start <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            winner <= pick;
            op_a   <= pick_a;
            op_b   <= pick_b;
            gnt    <= pick_oh;
            busy   <= 1'b1;
            if (pick_a == '0 || pick_b == '0) begin
              // gcd(x,0)=x and gcd(0,0)=0: the OR is the non-zero operand.
              rsp_valid <= pick_oh;
              rsp_ret   <= pick_a | pick_b;
              state     <= RESP;
            end else begin
              gcd_start <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          gcd_start <= 1'b0;
          state     <= SETTLE;
        end
        SETTLE: state <= WAIT;
        WAIT: begin
          if (gcd_done || timeout) begin
            rsp_ret   <= gcd_done ? gcd_ret : '0;
            rsp_valid <= gnt;
            state     <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= '0;
          gnt       <= '0;
          busy      <= 1'b0;
          ptr       <= (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Self-checking bench for gcd_arbiter: behavioural gcd stub, round-robin reference model, randomized jobs.
module tb_gcd_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int TO   = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req = '0;
  logic [NREQ*W-1:0]   req_a = '0;
  logic [NREQ*W-1:0]   req_b = '0;
  logic [NREQ-1:0]     gnt, rsp_valid;
  logic [W-1:0]        rsp_ret, gcd_a, gcd_b;
  logic                rsp_err, busy, gcd_start;
  logic                gcd_done = 1'b0;
  logic [W-1:0]        gcd_ret = '0;

  int errors = 0;
  int checks = 0;
  int mptr   = 0;
  logic [W-1:0] ma [NREQ];
  logic [W-1:0] mb [NREQ];

  int   stub_lat   = 1;
  bit   stub_stuck = 0;
  bit   stub_stale = 0;
  int   s_cnt      = 0;
  logic [W-1:0] s_a = '0, s_b = '0;

  typedef struct {
    bit              got;
    int              idx;
    logic [W-1:0]    ret;
    logic            err;
    int              cyc;
    int              starts;
    int              gnt_bad;
    logic [NREQ-1:0] gnt0;
    logic [W-1:0]    a0;
    logic [W-1:0]    b0;
  } obs_t;

  gcd_arbiter #(.NREQ(NREQ), .WIDTH(W), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ret(rsp_ret), .rsp_err(rsp_err),
    .busy(busy), .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
    .gcd_done(gcd_done), .gcd_ret(gcd_ret)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_gcd(logic [W-1:0] a, logic [W-1:0] b);
    logic [W-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Stub gcd unit: result after stub_lat cycles; optional stale done right after start.
  always @(posedge clk) begin
    gcd_done <= 1'b0;
    if (gcd_start) begin
      s_a   <= gcd_a;
      s_b   <= gcd_b;
      s_cnt <= stub_lat;
      if (stub_stale) begin
        gcd_done <= 1'b1;
        gcd_ret  <= 8'hFF;
      end
    end else if (s_cnt != 0) begin
      s_cnt <= s_cnt - 1;
      if (s_cnt == 1 && !stub_stuck) begin
        gcd_done <= 1'b1;
        gcd_ret  <= ref_gcd(s_a, s_b);
      end
    end
  end

  function automatic int model_pick(logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++)
      if (r[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    if ($urandom_range(0, 3) == 0) return '0;
    return W'($urandom_range(1, 255));
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    ma[i] = a;
    mb[i] = b;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mptr  = 0;
  endtask

  task automatic wait_rsp(input int budget, output obs_t o);
    bit seen;
    seen = 0;
    o.got = 0; o.idx = -1; o.ret = '0; o.err = 1'b0; o.cyc = 0;
    o.starts = 0; o.gnt_bad = 0; o.gnt0 = '0; o.a0 = '0; o.b0 = '0;
    while (!o.got && o.cyc < budget) begin
      @(negedge clk);
      o.cyc++;
      if (gcd_start) o.starts++;
      if (gnt != '0) begin
        if (!seen) begin
          seen = 1; o.gnt0 = gnt; o.a0 = gcd_a; o.b0 = gcd_b;
        end else if (gnt !== o.gnt0) o.gnt_bad++;
      end else if (seen) o.gnt_bad++;
      if (rsp_valid != '0) begin
        o.got = 1; o.ret = rsp_ret; o.err = rsp_err;
        for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) o.idx = i;
        if (rsp_valid !== gnt || $countones(rsp_valid) != 1) o.gnt_bad++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({gnt, rsp_valid, rsp_ret, rsp_err, busy, gcd_start, gcd_a, gcd_b} !== 35'd0) begin
      errors++; $display("FAIL reset_outputs got=%h exp=0", {gnt, rsp_valid, rsp_ret, rsp_err, busy, gcd_start, gcd_a, gcd_b}); end
    for (int i = 0; i < NREQ; i++) set_op(i, 8'd10, 8'd4);
    req = '1;
    @(negedge clk);
    checks++; if ({gnt, rsp_valid, busy, gcd_start} !== 10'd0) begin
      errors++; $display("FAIL reset_wins got=%h exp=0", {gnt, rsp_valid, busy, gcd_start}); end
    req   = '0;
    rst_n = 1'b1;
    mptr  = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    obs_t o;
    stub_lat = 1;
    set_op(0, 8'd48, 8'd18);
    req = 4'b0001;
    wait_rsp(50, o);
    req = '0;
    mptr = 1;
    checks++; if (!o.got)            begin errors++; $display("FAIL single_got no response in budget"); end
    checks++; if (o.idx != 0)        begin errors++; $display("FAIL single_idx got=%0d exp=0", o.idx); end
    checks++; if (o.ret !== 8'd6)    begin errors++; $display("FAIL single_ret got=%0d exp=6", o.ret); end
    checks++; if (o.err !== 1'b0)    begin errors++; $display("FAIL single_err got=%b exp=0", o.err); end
    checks++; if (o.cyc != 4)        begin errors++; $display("FAIL single_latency got=%0d exp=4", o.cyc); end
    checks++; if (o.starts != 1)     begin errors++; $display("FAIL single_start_cycles got=%0d exp=1", o.starts); end
    checks++; if (o.gnt0 !== 4'b0001) begin errors++; $display("FAIL single_gnt got=%b exp=0001", o.gnt0); end
    checks++; if (o.gnt_bad != 0)    begin errors++; $display("FAIL single_gnt_held bad_cycles=%0d exp=0", o.gnt_bad); end
    checks++; if ({o.a0, o.b0} !== {8'd48, 8'd18}) begin
      errors++; $display("FAIL single_operands got=%0d,%0d exp=48,18", o.a0, o.b0); end
    @(negedge clk);
  endtask

  task automatic test_two_req();
    obs_t o;
    do_reset();
    set_op(0, 8'd12, 8'd8);
    set_op(1, 8'd35, 8'd21);
    req = 4'b0011;
    wait_rsp(50, o);
    req[0] = 1'b0;
    checks++; if (o.idx != 0)     begin errors++; $display("FAIL two_first_idx got=%0d exp=0", o.idx); end
    checks++; if (o.ret !== 8'd4) begin errors++; $display("FAIL two_first_ret got=%0d exp=4", o.ret); end
    checks++; if (o.cyc != 4)     begin errors++; $display("FAIL two_first_latency got=%0d exp=4", o.cyc); end
    wait_rsp(50, o);
    req[1] = 1'b0;
    mptr = 2;
    checks++; if (o.idx != 1)     begin errors++; $display("FAIL two_second_idx got=%0d exp=1", o.idx); end
    checks++; if (o.ret !== 8'd7) begin errors++; $display("FAIL two_second_ret got=%0d exp=7", o.ret); end
    checks++; if (o.cyc != 5)     begin errors++; $display("FAIL two_second_latency got=%0d exp=5", o.cyc); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    obs_t o;
    int   exp_idx;
    do_reset();
    stub_lat = 2;
    for (int i = 0; i < NREQ; i++) set_op(i, W'($urandom_range(1, 255)), W'($urandom_range(1, 255)));
    req = '1;
    for (int j = 0; j < 6; j++) begin
      exp_idx = model_pick(req);
      wait_rsp(60, o);
      checks++; if (o.idx != exp_idx) begin errors++; $display("FAIL fair_idx job=%0d got=%0d exp=%0d", j, o.idx, exp_idx); end
      checks++; if (o.idx >= 0 && o.ret !== ref_gcd(ma[exp_idx], mb[exp_idx])) begin
        errors++; $display("FAIL fair_ret job=%0d got=%0d exp=%0d", j, o.ret, ref_gcd(ma[exp_idx], mb[exp_idx])); end
      checks++; if (o.cyc != ((j == 0) ? 0 : 1) + 3 + stub_lat) begin
        errors++; $display("FAIL fair_latency job=%0d got=%0d exp=%0d", j, o.cyc, ((j == 0) ? 0 : 1) + 3 + stub_lat); end
      mptr = (exp_idx + 1) % NREQ;
      set_op(exp_idx, W'($urandom_range(1, 255)), W'($urandom_range(1, 255)));
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    obs_t o;
    logic [W-1:0] za [2] = '{8'd0, 8'd0};
    logic [W-1:0] zb [2] = '{8'd9, 8'd0};
    for (int j = 0; j < 2; j++) begin
      set_op(2, za[j], zb[j]);
      req = 4'b0100;
      wait_rsp(20, o);
      req = '0;
      mptr = 3;
      checks++; if (o.idx != 2)         begin errors++; $display("FAIL zero_idx case=%0d got=%0d exp=2", j, o.idx); end
      checks++; if (o.ret !== zb[j])    begin errors++; $display("FAIL zero_ret case=%0d got=%0d exp=%0d", j, o.ret, zb[j]); end
      checks++; if (o.cyc != 1)         begin errors++; $display("FAIL zero_latency case=%0d got=%0d exp=1", j, o.cyc); end
      checks++; if (o.starts != 0)      begin errors++; $display("FAIL zero_no_start case=%0d starts=%0d exp=0", j, o.starts); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_job();
    obs_t o;
    stub_lat = 10;
    set_op(3, 8'd48, 8'd18);
    req = 4'b1000;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    set_op(0, 8'd12, 8'd8);
    req = 4'b1001;
    @(negedge clk);
    checks++; if ({gnt, rsp_valid, rsp_ret, rsp_err, busy, gcd_start, gcd_a, gcd_b} !== 35'd0) begin
      errors++; $display("FAIL midreset_outputs got=%h exp=0", {gnt, rsp_valid, rsp_ret, rsp_err, busy, gcd_start, gcd_a, gcd_b}); end
    rst_n = 1'b1;
    mptr = 0;
    stub_lat = 3;
    // ptr back at 0 makes requester 0 win over 3; a surviving ptr of 3 would pick 3 first.
    wait_rsp(50, o);
    req[0] = 1'b0;
    checks++; if (o.idx != 0 || o.ret !== 8'd4) begin
      errors++; $display("FAIL midreset_ptr idx=%0d ret=%0d exp idx=0 ret=4", o.idx, o.ret); end
    wait_rsp(50, o);
    req[3] = 1'b0;
    mptr = 0;
    checks++; if (o.idx != 3)     begin errors++; $display("FAIL midreset_reissue_idx got=%0d exp=3", o.idx); end
    checks++; if (o.ret !== 8'd6) begin errors++; $display("FAIL midreset_reissue_ret got=%0d exp=6", o.ret); end
    @(negedge clk);
  endtask

  task automatic test_random();
    obs_t o;
    int   exp_idx, exp_cyc;
    logic [W-1:0] exp_ret;
    req = '0;
    for (int i = 0; i < NREQ; i++) set_op(i, rnd_op(), rnd_op());
    req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
    for (int j = 0; j < 30; j++) begin
      stub_lat   = $urandom_range(1, 4);
      stub_stale = $urandom_range(0, 1);
      exp_idx = model_pick(req);
      exp_ret = ref_gcd(ma[exp_idx], mb[exp_idx]);
      exp_cyc = ((j == 0) ? 0 : 1) + ((ma[exp_idx] == 0 || mb[exp_idx] == 0) ? 1 : 3 + stub_lat);
      wait_rsp(60, o);
      checks++; if (o.idx != exp_idx) begin errors++; $display("FAIL rand_idx job=%0d got=%0d exp=%0d", j, o.idx, exp_idx); end
      checks++; if (o.ret !== exp_ret) begin errors++; $display("FAIL rand_ret job=%0d got=%0d exp=%0d", j, o.ret, exp_ret); end
      checks++; if (o.err !== 1'b0)   begin errors++; $display("FAIL rand_err job=%0d got=%b exp=0", j, o.err); end
      checks++; if (o.cyc != exp_cyc) begin errors++; $display("FAIL rand_latency job=%0d got=%0d exp=%0d", j, o.cyc, exp_cyc); end
      checks++; if (o.gnt_bad != 0)   begin errors++; $display("FAIL rand_gnt_held job=%0d bad_cycles=%0d exp=0", j, o.gnt_bad); end
      mptr = (exp_idx + 1) % NREQ;
      req[exp_idx] = 1'b0;
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          set_op(i, rnd_op(), rnd_op());
          req[i] = 1'b1;
        end
      if (req == '0) begin
        set_op(exp_idx, rnd_op(), rnd_op());
        req[exp_idx] = 1'b1;
      end
    end
    req = '0;
    stub_stale = 0;
    @(negedge clk);
  endtask

  task automatic test_stuck_done();
    obs_t o;
    stub_stuck = 1;
    stub_lat   = 1;
    set_op(1, 8'd48, 8'd18);
    req = 4'b0010;
    wait_rsp(60, o);
`ifdef GCD_ARB_TIMEOUT_EN
    req = '0;
    checks++; if (!o.got || o.idx != 1) begin errors++; $display("FAIL timeout_rsp got=%0d idx=%0d exp got=1 idx=1", o.got, o.idx); end
    checks++; if (o.err !== 1'b1)       begin errors++; $display("FAIL timeout_err got=%b exp=1", o.err); end
    checks++; if (o.ret !== 8'd0)       begin errors++; $display("FAIL timeout_ret got=%0d exp=0", o.ret); end
    checks++; if (o.cyc != 3 + TO)      begin errors++; $display("FAIL timeout_latency got=%0d exp=%0d", o.cyc, 3 + TO); end
`else
    checks++; if (o.got)           begin errors++; $display("FAIL stuck_no_rsp got response idx=%0d", o.idx); end
    checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL stuck_busy got=%b exp=1", busy); end
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL stuck_gnt got=%b exp=0010", gnt); end
`endif
    stub_stuck = 0;
    do_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_two_req();
    test_back_to_back();
    test_zero();
    test_reset_mid_job();
    test_random();
    test_stuck_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
